prbs_test_ctrl: RTL and testbench
=================================

Name: prbs_test_ctrl

Overview:
- Test sequencer for the 8-bit Galois LFSR generator and LFSR checker pair.
- On a start command it:
  - seeds the generator through its synchronous soft-reset port,
  - streams i_valid while waiting for checker lock (with a timeout),
  - runs a programmable-length measurement window counting lock losses,
  - optionally injects single-cycle corruptions,
  - reports pass/fail.
- Sits above the generator/checker top-level and drives its i_valid, i_soft_reset, i_seed and i_corrupt inputs; consumes o_lock.

Parameters:
- SEED_W, 8, width of seed / LFSR state.
- CNT_W, 16, width of the run-length and lock-loss counters.
- LOCK_TIMEOUT, 64, max ACQUIRE cycles before declaring timeout (>=1).
- DEFAULT_SEED, 8'h01, seed substituted when the requested seed is all-zero.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_start  input  1  start-test request; sampled only in IDLE or DONE.
- i_seed  input  SEED_W  requested seed; latched on accepted start.
- i_num_cycles  input  CNT_W  measurement window length in cycles; latched on accepted start.
- i_inject_err  input  1  request one-cycle corruption; honoured only in MEASURE.
- i_lock  input  1  lock indication from checker.
- o_valid  output  1  advance generator/checker.
- o_soft_reset  output  1  synchronous seed load to generator.
- o_seed  output  SEED_W  seed value to generator/checker.
- o_corrupt  output  1  corrupt generator-to-checker path this cycle.
- o_busy  output  1  test in progress (SEED, ACQUIRE, MEASURE).
- o_done  output  1  one-cycle pulse on test completion.
- o_pass  output  1  result of last test; valid from o_done, held until next accepted start.
- o_timeout  output  1  last test failed to acquire lock; held like o_pass.
- o_lock_lost_cnt  output  CNT_W  1->0 transitions of i_lock during MEASURE; saturating.

Behaviour:
- Reset (i_rst=1 at clk edge, any state, including mid-test):
  - state=IDLE.
  - o_valid, o_soft_reset, o_corrupt, o_busy, o_done, o_pass and o_timeout all 0.
  - o_seed=DEFAULT_SEED; counters=0; pending injection cleared.
- States: IDLE, SEED, ACQUIRE, MEASURE, DONE. All outputs are registered.
- IDLE:
  - o_valid=0.
  - On i_start=1: latch i_seed and i_num_cycles. A latched seed of 0 is replaced by DEFAULT_SEED.
  - Also on start: clear o_lock_lost_cnt, o_pass, o_timeout and the internal counters; go to SEED.
- SEED (exactly 1 cycle):
  - o_soft_reset=1, o_seed=latched seed, o_valid=0; then go to ACQUIRE.
  - o_seed holds the latched value until the next accepted start.
- ACQUIRE:
  - o_valid=1 every cycle; wait counter increments from 0.
  - i_lock=1 sampled -> go to MEASURE with run counter=0.
  - Otherwise, when wait counter reaches LOCK_TIMEOUT-1 -> go to DONE with timeout=1, pass=0.
  - If lock and timeout occur in the same cycle, lock wins.
- MEASURE:
  - o_valid=1; run counter increments each cycle.
  - Previous-cycle i_lock is registered. prev=1 and current=0 increments o_lock_lost_cnt, saturating at all-ones.
  - Exit to DONE on the cycle the run counter equals latched num_cycles-1.
  - num_cycles=0 exits to DONE on the first MEASURE cycle, with 0 lock-loss checks.
  - Pass condition at exit: o_lock_lost_cnt==0 (including a loss detected in the final cycle) and i_lock=1 in the final cycle.
- Error injection:
  - i_inject_err=1 sampled in MEASURE -> o_corrupt=1 for exactly the next cycle.
  - Multi-cycle assertion of i_inject_err produces one o_corrupt per sampled cycle, so the pulse train is delayed by 1 cycle.
  - Ignored in all other states. o_corrupt is forced 0 in the cycle after leaving MEASURE.
- DONE:
  - o_done=1 for the single cycle of entry; o_valid=0, o_busy=0.
  - Results and counters are held.
  - Same-cycle i_start is accepted (same as IDLE); otherwise go to IDLE.
- i_start in SEED/ACQUIRE/MEASURE is ignored; there is no abort other than i_rst.
- o_busy=1 exactly in SEED, ACQUIRE and MEASURE.

Test Plan:
- Reset value check: i_rst=1 for 2 cycles, then release with i_start=0 -> all 1-bit outputs 0, o_seed=8'h01, o_lock_lost_cnt=0, state stays IDLE.
- Nominal pass, with the bench modelling the checker: i_seed=8'hA5, i_num_cycles=100, i_lock rises 5 cycles into ACQUIRE and stays 1 ->
  - o_soft_reset high 1 cycle with o_seed=8'hA5;
  - o_valid high 105 consecutive cycles;
  - o_done pulse one cycle later, o_pass=1, o_lock_lost_cnt=0.
- Timeout: i_lock held 0, LOCK_TIMEOUT=64 -> o_valid high exactly 64 cycles, then o_done=1, o_timeout=1, o_pass=0.
- Injection and loss count: num_cycles=200; pulse i_inject_err at MEASURE cycle 10 ->
  - o_corrupt high exactly at cycle 11;
  - bench drops i_lock for cycles 13-15 and again at 50-51 -> o_lock_lost_cnt=2, o_pass=0.
- Boundary cases:
  - i_seed=0 -> o_seed=8'h01 during SEED.
  - i_num_cycles=0 -> o_done 2 cycles after lock entry, o_pass=1.
  - i_start held high during a run -> no restart until DONE.
- Reset mid-MEASURE: at run cycle 50, assert i_rst for 1 cycle -> o_valid=0 and o_busy=0 the next cycle, o_done never pulses, counters=0.

Source files
------------

// File: rtl/prbs_test_ctrl_if.sv
// ---------------------------------------------------------------------------
// prbs_test_ctrl_if
// Bundles the command/status and generator/checker control signals of the
// PRBS test sequencer. Signal names keep the controller's point of view:
// i_* are driven into the controller, o_* are driven by it.
//
//   i_start         start-test request
//   i_seed          requested LFSR seed
//   i_num_cycles    measurement window length
//   i_inject_err    request a one-cycle corruption
//   i_lock          checker lock indication
//   o_valid         advance generator/checker
//   o_soft_reset    synchronous seed load to generator
//   o_seed          seed value to generator/checker
//   o_corrupt       corrupt generator-to-checker path this cycle
//   o_busy          test in progress
//   o_done          one-cycle completion pulse
//   o_pass          result of last test
//   o_timeout       last test failed to acquire lock
//   o_lock_lost_cnt lock-loss count of last/current measurement
//
// Modports: master = the controller, slave = its environment.
// ---------------------------------------------------------------------------
interface prbs_test_ctrl_if #(
    parameter int SEED_W = 8,
    parameter int CNT_W  = 16
);
    logic              i_start;
    logic [SEED_W-1:0] i_seed;
    logic [CNT_W-1:0]  i_num_cycles;
    logic              i_inject_err;
    logic              i_lock;
    logic              o_valid;
    logic              o_soft_reset;
    logic [SEED_W-1:0] o_seed;
    logic              o_corrupt;
    logic              o_busy;
    logic              o_done;
    logic              o_pass;
    logic              o_timeout;
    logic [CNT_W-1:0]  o_lock_lost_cnt;

    modport master (
        input  i_start, i_seed, i_num_cycles, i_inject_err, i_lock,
        output o_valid, o_soft_reset, o_seed, o_corrupt, o_busy, o_done,
               o_pass, o_timeout, o_lock_lost_cnt
    );

    modport slave (
        output i_start, i_seed, i_num_cycles, i_inject_err, i_lock,
        input  o_valid, o_soft_reset, o_seed, o_corrupt, o_busy, o_done,
               o_pass, o_timeout, o_lock_lost_cnt
    );
endinterface

// File: rtl/prbs_test_ctrl.sv
// ---------------------------------------------------------------------------
// prbs_test_ctrl
// Test sequencer for an 8-bit LFSR generator/checker pair. A start command
// seeds the generator, streams valid until the checker locks (or times out),
// runs a measurement window counting lock losses, optionally injects
// single-cycle corruptions and reports pass/fail.
//
//   clk   rising-edge clock
//   i_rst synchronous, active-high reset
//   bus   prbs_test_ctrl_if.master (command, status, generator control)
//
// Every output is a register loaded from the next-state logic, so an output
// "in state X" is high exactly during the cycles the FSM sits in X.
// ---------------------------------------------------------------------------
module prbs_test_ctrl #(
    parameter int                SEED_W       = 8,
    parameter int                CNT_W        = 16,
    parameter int                LOCK_TIMEOUT = 64,
    parameter logic [SEED_W-1:0] DEFAULT_SEED = 8'h01
) (
    input  logic              clk,
    input  logic              i_rst,
    prbs_test_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_ACQUIRE,
        ST_MEASURE,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t            r_state;
    logic [SEED_W-1:0] r_seed;
    logic [CNT_W-1:0]  r_num_cycles;
    logic [CNT_W-1:0]  r_cyc_cnt;      // ACQUIRE wait counter, then MEASURE run counter
    logic [CNT_W-1:0]  r_lost_cnt;
    logic              r_lock_prev;
    logic              r_valid;
    logic              r_soft_reset;
    logic              r_corrupt;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;

    state_t            w_state_nxt;
    logic [SEED_W-1:0] w_seed_nxt;
    logic [CNT_W-1:0]  w_num_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_lost_nxt;
    logic              w_corrupt_nxt;
    logic              w_pass_nxt;
    logic              w_timeout_nxt;
    logic              w_last_run;

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_seed_nxt    = r_seed;
        w_num_nxt     = r_num_cycles;
        w_cnt_nxt     = r_cyc_cnt;
        w_lost_nxt    = r_lost_cnt;
        w_corrupt_nxt = 1'b0;
        w_pass_nxt    = r_pass;
        w_timeout_nxt = r_timeout;
        w_last_run    = (r_num_cycles == '0) || (r_cyc_cnt == r_num_cycles - CNT_ONE);

        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (bus.i_start) begin
                    // An all-zero seed would lock the LFSR up, so substitute.
                    w_seed_nxt    = (bus.i_seed == '0) ? DEFAULT_SEED : bus.i_seed;
                    w_num_nxt     = bus.i_num_cycles;
                    w_cnt_nxt     = '0;
                    w_lost_nxt    = '0;
                    w_pass_nxt    = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = ST_SEED;
                end
            end
            ST_SEED: begin
                w_state_nxt = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                // Lock is tested first so it wins over a coincident timeout.
                if (bus.i_lock) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_MEASURE;
                end else if (r_cyc_cnt == TIMEOUT_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_pass_nxt    = 1'b0;
                    w_state_nxt   = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cyc_cnt + CNT_ONE;
                end
            end
            ST_MEASURE: begin
                // A zero-length window performs no lock-loss checks at all.
                if (r_num_cycles != '0 && r_lock_prev && !bus.i_lock && r_lost_cnt != '1) begin
                    w_lost_nxt = r_lost_cnt + CNT_ONE;
                end
                w_cnt_nxt = r_cyc_cnt + CNT_ONE;
                if (w_last_run) begin
                    // Uses the updated count so a loss in the final cycle fails.
                    w_pass_nxt  = (w_lost_nxt == '0) && bus.i_lock;
                    w_state_nxt = ST_DONE;
                end else begin
                    // A request in the final cycle is dropped: no corruption in DONE.
                    w_corrupt_nxt = bus.i_inject_err;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_seed       <= DEFAULT_SEED;
            r_num_cycles <= '0;
            r_cyc_cnt    <= '0;
            r_lost_cnt   <= '0;
            r_lock_prev  <= 1'b0;
            r_valid      <= 1'b0;
            r_soft_reset <= 1'b0;
            r_corrupt    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_seed       <= w_seed_nxt;
            r_num_cycles <= w_num_nxt;
            r_cyc_cnt    <= w_cnt_nxt;
            r_lost_cnt   <= w_lost_nxt;
            r_lock_prev  <= bus.i_lock;
            r_valid      <= (w_state_nxt == ST_ACQUIRE) || (w_state_nxt == ST_MEASURE);
            r_soft_reset <= (w_state_nxt == ST_SEED);
            r_corrupt    <= w_corrupt_nxt;
            r_busy       <= (w_state_nxt == ST_SEED) || (w_state_nxt == ST_ACQUIRE) ||
                            (w_state_nxt == ST_MEASURE);
            r_done       <= (w_state_nxt == ST_DONE);
            r_pass       <= w_pass_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    assign bus.o_valid         = r_valid;
    assign bus.o_soft_reset    = r_soft_reset;
    assign bus.o_seed          = r_seed;
    assign bus.o_corrupt       = r_corrupt;
    assign bus.o_busy          = r_busy;
    assign bus.o_done          = r_done;
    assign bus.o_pass          = r_pass;
    assign bus.o_timeout       = r_timeout;
    assign bus.o_lock_lost_cnt = r_lost_cnt;

endmodule

// File: tb/tb_prbs_test_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prbs_test_ctrl
// Self-checking bench for prbs_test_ctrl. Whole-test scenarios come from a
// vector table; injection, held start and mid-run reset use hand sequences.
// The bench plays the checker: i_lock follows o_valid with a per-scenario
// delay.
// ---------------------------------------------------------------------------
module tb_prbs_test_ctrl;

    localparam int SEED_W       = 8;
    localparam int CNT_W        = 16;
    localparam int LOCK_TIMEOUT = 64;

    logic clk = 1'b0;
    logic i_rst;

    always #5 clk = ~clk;

    prbs_test_ctrl_if #(.SEED_W(SEED_W), .CNT_W(CNT_W)) bus ();

    prbs_test_ctrl #(
        .SEED_W      (SEED_W),
        .CNT_W       (CNT_W),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .DEFAULT_SEED(8'h01)
    ) dut (
        .clk  (clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  seed;
        logic [15:0] num;
        int          lock_after;  // lock rises on this o_valid cycle (1-based); 0 = never
        logic [7:0]  exp_seed;
        int          exp_valid;
        logic        exp_pass;
        logic        exp_timeout;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_test(input logic [7:0] seed, input logic [15:0] num);
        bus.i_seed       = seed;
        bus.i_num_cycles = num;
        bus.i_start      = 1'b1;
        tick();
        bus.i_start      = 1'b0;
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        int          cyc = 0;
        int          soft_cnt = 0;
        int          valid_cnt = 0;
        int          first_valid = -1;
        int          last_valid = -1;
        int          done_cyc = -1;
        int          busy_drop = 0;
        logic [7:0]  soft_seed = '0;
        logic [2:0]  seed_flags = '1;
        logic        pass_v = 1'b0;
        logic        to_v = 1'b0;
        logic [15:0] lost_v = '1;
        string       p;
        p = $sformatf("v%0d_", idx);
        bus.i_lock = 1'b0;
        start_test(v.seed, v.num);
        while (done_cyc < 0 && cyc < 1000) begin
            if (bus.o_soft_reset) begin
                soft_cnt++;
                soft_seed  = bus.o_seed;
                seed_flags = {bus.o_pass, bus.o_timeout, bus.o_lock_lost_cnt != 0};
            end
            if (bus.o_valid) begin
                if (first_valid < 0) first_valid = cyc;
                valid_cnt++;
                last_valid = cyc;
            end
            if (bus.o_done) begin
                done_cyc = cyc;
                pass_v   = bus.o_pass;
                to_v     = bus.o_timeout;
                lost_v   = bus.o_lock_lost_cnt;
            end else begin
                if (!bus.o_busy) busy_drop++;
                bus.i_lock = (v.lock_after > 0) && (valid_cnt >= v.lock_after);
                tick();
                cyc++;
            end
        end
        check({p, "done_seen"},    done_cyc >= 0, 1);
        check({p, "soft_pulses"},  soft_cnt, 1);
        check({p, "soft_seed"},    soft_seed, v.exp_seed);
        check({p, "seed_flags"},   seed_flags, 3'b000);
        check({p, "valid_cycles"}, valid_cnt, v.exp_valid);
        check({p, "valid_contig"}, last_valid - first_valid + 1, valid_cnt);
        check({p, "done_after"},   done_cyc, last_valid + 1);
        check({p, "busy_held"},    busy_drop, 0);
        check({p, "pass"},         pass_v, v.exp_pass);
        check({p, "timeout"},      to_v, v.exp_timeout);
        check({p, "lost_cnt"},     lost_v, 0);
        bus.i_lock = 1'b0;
        tick();
        check({p, "done_pulse_end"}, {bus.o_done, bus.o_busy, bus.o_valid}, 3'b000);
        check({p, "result_held"},    {bus.o_pass, bus.o_timeout}, {v.exp_pass, v.exp_timeout});
    endtask

    initial begin
        int          cyc;
        int          valid_cnt;
        int          m;
        int          corrupt_bad;
        int          corrupt_cnt;
        int          done_cnt;
        int          soft_cnt;
        logic        prev_inj_meas;
        logic        in_meas;
        logic        inj;
        logic        exp_c;
        logic        done;
        logic [15:0] lost_at20;
        logic [15:0] lost_at52;
        logic [15:0] lost_v;
        logic        pass_v;
        logic        to_v;
        logic [7:0]  seed_at_done;

        vecs[0] = '{seed: 8'hA5, num: 16'd100, lock_after: 5,  exp_seed: 8'hA5, exp_valid: 105, exp_pass: 1'b1, exp_timeout: 1'b0};
        vecs[1] = '{seed: 8'h00, num: 16'd10,  lock_after: 3,  exp_seed: 8'h01, exp_valid: 13,  exp_pass: 1'b1, exp_timeout: 1'b0};
        vecs[2] = '{seed: 8'h3C, num: 16'd20,  lock_after: 0,  exp_seed: 8'h3C, exp_valid: 64,  exp_pass: 1'b0, exp_timeout: 1'b1};
        vecs[3] = '{seed: 8'h7E, num: 16'd0,   lock_after: 1,  exp_seed: 8'h7E, exp_valid: 2,   exp_pass: 1'b1, exp_timeout: 1'b0};
        vecs[4] = '{seed: 8'hFF, num: 16'd1,   lock_after: 64, exp_seed: 8'hFF, exp_valid: 65,  exp_pass: 1'b1, exp_timeout: 1'b0};

        i_rst            = 1'b1;
        bus.i_start      = 1'b0;
        bus.i_seed       = '0;
        bus.i_num_cycles = '0;
        bus.i_inject_err = 1'b0;
        bus.i_lock       = 1'b0;

        // Reset values.
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        check("rst_flags", {bus.o_valid, bus.o_soft_reset, bus.o_corrupt, bus.o_busy,
                            bus.o_done, bus.o_pass, bus.o_timeout}, 7'b0);
        check("rst_seed", bus.o_seed, 8'h01);
        check("rst_lost", bus.o_lock_lost_cnt, 0);
        tick();
        check("rst_idle", {bus.o_busy, bus.o_soft_reset}, 2'b00);

        // Table-driven whole-test scenarios.
        for (int i = 0; i < 5; i++) run_vector(vecs[i], i);

        // Injection and lock-loss counting. Lock after the first ACQUIRE cycle,
        // so MEASURE cycle m is the (m+2)-th o_valid cycle.
        start_test(8'h5A, 16'd200);
        cyc = 0; valid_cnt = 0; corrupt_bad = 0; corrupt_cnt = 0;
        prev_inj_meas = 1'b0; done = 1'b0;
        lost_at20 = '1; lost_at52 = '1; lost_v = '1; pass_v = 1'b1; to_v = 1'b1;
        while (!done && cyc < 1000) begin
            exp_c = prev_inj_meas && bus.o_valid;
            if (bus.o_corrupt !== exp_c) corrupt_bad++;
            if (bus.o_corrupt) corrupt_cnt++;
            if (bus.o_valid) valid_cnt++;
            m = valid_cnt - 2;
            if (bus.o_done) begin
                done   = 1'b1;
                lost_v = bus.o_lock_lost_cnt;
                pass_v = bus.o_pass;
                to_v   = bus.o_timeout;
            end else begin
                in_meas = bus.o_valid && (valid_cnt >= 2);
                if (in_meas && m == 20) lost_at20 = bus.o_lock_lost_cnt;
                if (in_meas && m == 52) lost_at52 = bus.o_lock_lost_cnt;
                bus.i_lock = bus.o_valid &&
                             !(in_meas && ((m >= 13 && m <= 15) || (m >= 50 && m <= 51)));
                // The ACQUIRE-cycle request must be ignored.
                inj = (bus.o_valid && valid_cnt == 1) ||
                      (in_meas && (m == 10 || (m >= 100 && m <= 102) || m == 199));
                bus.i_inject_err = inj;
                prev_inj_meas    = inj && in_meas;
                tick();
                cyc++;
            end
        end
        bus.i_inject_err = 1'b0;
        bus.i_lock       = 1'b0;
        check("inj_done_seen",   done, 1'b1);
        check("inj_valid",       valid_cnt, 201);
        check("inj_corrupt_err", corrupt_bad, 0);
        check("inj_corrupt_cnt", corrupt_cnt, 4);
        check("inj_lost_at20",   lost_at20, 1);
        check("inj_lost_at52",   lost_at52, 2);
        check("inj_lost_final",  lost_v, 2);
        check("inj_pass",        pass_v, 1'b0);
        check("inj_timeout",     to_v, 1'b0);
        tick();

        // i_start held through a run: no restart until DONE, then accepted there.
        bus.i_seed = 8'h11; bus.i_num_cycles = 16'd3; bus.i_start = 1'b1;
        tick();
        cyc = 0; soft_cnt = 0; done = 1'b0; seed_at_done = '0;
        while (!done && cyc < 200) begin
            if (bus.o_soft_reset) soft_cnt++;
            if (bus.o_done) begin
                done = 1'b1;
                seed_at_done = bus.o_seed;
            end else begin
                bus.i_lock = bus.o_valid;
                if (cyc == 2) bus.i_seed = 8'h22;
                tick();
                cyc++;
            end
        end
        check("hold_done_cyc",  cyc, 5);
        check("hold_soft_cnt",  soft_cnt, 1);
        check("hold_seed_kept", seed_at_done, 8'h11);
        bus.i_lock = 1'b0;
        tick();
        bus.i_start = 1'b0;
        check("hold_restart", {bus.o_soft_reset, bus.o_busy}, 2'b11);
        check("hold_new_seed", bus.o_seed, 8'h22);
        cyc = 0; done = 1'b0; pass_v = 1'b0;
        while (!done && cyc < 200) begin
            if (bus.o_done) begin
                done   = 1'b1;
                pass_v = bus.o_pass;
            end else begin
                bus.i_lock = bus.o_valid;
                tick();
                cyc++;
            end
        end
        check("hold_second_pass", {done, pass_v}, 2'b11);
        bus.i_lock = 1'b0;
        tick();

        // Reset in the middle of MEASURE, with a loss counted and an injection pending.
        start_test(8'h33, 16'd200);
        cyc = 0; valid_cnt = 0; m = -2;
        while (m != 50 && cyc < 1000) begin
            if (bus.o_valid) valid_cnt++;
            m = valid_cnt - 2;
            if (m != 50) begin
                bus.i_lock = bus.o_valid && !(valid_cnt >= 2 && m == 20);
                tick();
                cyc++;
            end
        end
        check("mrst_reached", m, 50);
        check("mrst_lost_before", bus.o_lock_lost_cnt, 1);
        bus.i_inject_err = 1'b1;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        bus.i_inject_err = 1'b0;
        bus.i_lock = 1'b0;
        check("mrst_flags", {bus.o_valid, bus.o_busy, bus.o_corrupt, bus.o_soft_reset,
                             bus.o_done}, 5'b0);
        check("mrst_lost", bus.o_lock_lost_cnt, 0);
        check("mrst_seed", bus.o_seed, 8'h01);
        done_cnt = 0; valid_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            if (bus.o_done) done_cnt++;
            if (bus.o_valid || bus.o_busy) valid_cnt++;
            tick();
        end
        check("mrst_no_done", done_cnt, 0);
        check("mrst_idle",    valid_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
